// File: rtl/riscv_core_dpath_iter_muldiv.sv
// ---------------------------------------------------------------------------
// riscv_core_dpath_iter_muldiv
//
// Iterative RV32M multiply/divide unit that sits beside the ALU in X.
// One radix-2 step per cycle: shift-add for multiply, restoring division for
// divide. Both work on operand magnitudes, and the sign is applied on the way
// out from flags captured when the request is accepted. Latency is fixed at
// WIDTH+1 cycles from the accepting cycle to resp_val for every function and
// operand. Divide-by-zero and signed overflow take the same fixed latency.
//
// Ports
//   clk        clock, rising edge
//   reset      asynchronous, active-high; returns the unit to IDLE at once
//   req_val    request valid
//   req_rdy    unit can accept a request (IDLE and not killed)
//   req_fn     0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//   req_a      operand A (multiplicand / dividend)
//   req_b      operand B (multiplier / divisor)
//   req_tag    opaque tag returned on resp_tag
//   kill       synchronous squash of any accepted operation
//   resp_val   result valid (DONE state)
//   resp_rdy   consumer accepts the result
//   resp_data  result, zero outside DONE
//   resp_tag   tag of the operation producing resp_data, zero outside DONE
//   busy       unit is not IDLE
// ---------------------------------------------------------------------------
module riscv_core_dpath_iter_muldiv #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_val,
    output logic             req_rdy,
    input  logic [2:0]       req_fn,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             kill,
    output logic             resp_val,
    input  logic             resp_rdy,
    output logic [WIDTH-1:0] resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    typedef enum logic [2:0] {
        FN_MUL    = 3'd0,
        FN_MULH   = 3'd1,
        FN_MULHSU = 3'd2,
        FN_MULHU  = 3'd3,
        FN_DIV    = 3'd4,
        FN_DIVU   = 3'd5,
        FN_REM    = 3'd6,
        FN_REMU   = 3'd7
    } fn_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    fn_t               fn_q;
    logic [TAG_W-1:0]  tag_q;
    // opnd_q holds |A| for multiply (the addend) and |B| for divide (the divisor).
    logic [WIDTH-1:0]  opnd_q;
    // acc_hi_q:acc_lo_q is the product for multiply; remainder:quotient for divide.
    logic [WIDTH-1:0]  acc_hi_q;
    logic [WIDTH-1:0]  acc_lo_q;
    logic              neg_q;
    logic              spec_q;
    logic [WIDTH-1:0]  spec_res_q;

    logic fire;

    // -----------------------------------------------------------------------
    // Handshake and status
    // -----------------------------------------------------------------------
    assign req_rdy  = (state_q == S_IDLE) && !kill && !reset;
    assign fire     = req_val && req_rdy;
    assign busy     = (state_q != S_IDLE);
    assign resp_val = (state_q == S_DONE);

    // -----------------------------------------------------------------------
    // Request decode: signedness, magnitudes, result sign, special cases
    // -----------------------------------------------------------------------
    logic             is_div;
    logic             is_rem;
    logic             sign_a;
    logic             sign_b;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             res_neg;
    logic             div_zero;
    logic             div_ovf;
    logic             spec;
    logic [WIDTH-1:0] spec_res;

    // NOTE: every always_comb output gets a default before any branch, so no
    // path can leave a signal unassigned and infer a latch.
    always_comb begin
        is_div   = req_fn[2];
        is_rem   = req_fn[2] & req_fn[1];
        // Divide ops: bit 0 set means unsigned. Multiply: MULHU is fully
        // unsigned, MULHSU keeps A signed only.
        sign_a   = is_div ? ~req_fn[0] : ~(req_fn[1] & req_fn[0]);
        sign_b   = is_div ? ~req_fn[0] : ~req_fn[1];
        a_neg    = sign_a & req_a[WIDTH-1];
        b_neg    = sign_b & req_b[WIDTH-1];
        mag_a    = a_neg ? (~req_a + 1'b1) : req_a;
        mag_b    = b_neg ? (~req_b + 1'b1) : req_b;
        // Remainder follows the dividend; product and quotient follow sA^sB.
        res_neg  = is_rem ? a_neg : (a_neg ^ b_neg);
        div_zero = (req_b == '0);
        div_ovf  = ~req_fn[0] & (req_a == MIN_VAL) & (&req_b);
        spec     = is_div & (div_zero | div_ovf);
        spec_res = '0;
        if (div_zero) begin
            spec_res = is_rem ? req_a : '1;
        end else if (div_ovf) begin
            spec_res = is_rem ? '0 : MIN_VAL;
        end
    end

    // -----------------------------------------------------------------------
    // One iteration step
    // -----------------------------------------------------------------------
    logic [WIDTH:0]   mul_pa;
    logic [WIDTH-1:0] mul_hi;
    logic [WIDTH-1:0] mul_lo;
    logic [WIDTH:0]   div_sh;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;
    logic [WIDTH-1:0] div_hi;
    logic [WIDTH-1:0] div_lo;

    always_comb begin
        // Shift-add: add the multiplicand when the current multiplier bit is
        // set, then shift the whole 2*WIDTH+1 partial product right by one.
        mul_pa   = acc_lo_q[0] ? ({1'b0, acc_hi_q} + {1'b0, opnd_q})
                               : {1'b0, acc_hi_q};
        mul_hi   = mul_pa[WIDTH:1];
        mul_lo   = {mul_pa[0], acc_lo_q[WIDTH-1:1]};

        // Restoring division: bring in the next dividend bit, subtract the
        // divisor if it fits, and shift the outcome into the quotient.
        // The remainder stays below the divisor, so the difference fits WIDTH bits.
        div_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_ge   = (div_sh >= {1'b0, opnd_q});
        div_diff = div_sh[WIDTH-1:0] - opnd_q;
        div_hi   = div_ge ? div_diff : div_sh[WIDTH-1:0];
        div_lo   = {acc_lo_q[WIDTH-2:0], div_ge};
    end

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (fire) begin
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (kill) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (kill || resp_rdy) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    // NOTE: the datapath registers are reset as well as the state, so a
    // response can never expose operands left over from before a reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            fn_q       <= FN_MUL;
            tag_q      <= '0;
            opnd_q     <= '0;
            acc_hi_q   <= '0;
            acc_lo_q   <= '0;
            neg_q      <= 1'b0;
            spec_q     <= 1'b0;
            spec_res_q <= '0;
        end else if (fire) begin
            cnt_q      <= CNT_W'(WIDTH);
            fn_q       <= fn_t'(req_fn);
            tag_q      <= req_tag;
            opnd_q     <= is_div ? mag_b : mag_a;
            acc_hi_q   <= '0;
            acc_lo_q   <= is_div ? mag_a : mag_b;
            neg_q      <= res_neg;
            spec_q     <= spec;
            spec_res_q <= spec_res;
        end else if (state_q == S_CALC) begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (fn_q[2]) begin
                acc_hi_q <= div_hi;
                acc_lo_q <= div_lo;
            end else begin
                acc_hi_q <= mul_hi;
                acc_lo_q <= mul_lo;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Result: apply the registered sign, select the field, override specials
    // -----------------------------------------------------------------------
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;
    logic [WIDTH-1:0]   result;

    always_comb begin
        prod_s = neg_q ? (~{acc_hi_q, acc_lo_q} + 1'b1) : {acc_hi_q, acc_lo_q};
        quo_s  = neg_q ? (~acc_lo_q + 1'b1) : acc_lo_q;
        rem_s  = neg_q ? (~acc_hi_q + 1'b1) : acc_hi_q;
        result = '0;
        unique case (fn_q)
            FN_MUL:                        result = prod_s[WIDTH-1:0];
            FN_MULH, FN_MULHSU, FN_MULHU:  result = prod_s[2*WIDTH-1:WIDTH];
            FN_DIV, FN_DIVU:               result = quo_s;
            FN_REM, FN_REMU:               result = rem_s;
            default:                       result = '0;
        endcase
        if (spec_q) begin
            result = spec_res_q;
        end
    end

    assign resp_data = (state_q == S_DONE) ? result : '0;
    assign resp_tag  = (state_q == S_DONE) ? tag_q  : '0;

endmodule

// File: tb/tb_riscv_core_dpath_iter_muldiv.sv
// ---------------------------------------------------------------------------
// tb_riscv_core_dpath_iter_muldiv
//
// Directed bench for the iterative mul/div unit (WIDTH=32, TAG_W=5).
// Stimulus pushes the hand-computed result, tag and accepting cycle into a
// scoreboard queue; a monitor pops on each resp_val/resp_rdy handshake and
// compares data, tag and the fixed WIDTH+1 latency.
// ---------------------------------------------------------------------------
module tb_riscv_core_dpath_iter_muldiv;

    localparam int WIDTH = 32;
    localparam int TAG_W = 5;
    localparam int LAT   = WIDTH + 1;

    localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
    localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM    = 3'd6, REMU  = 3'd7;

    logic             clk = 1'b0;
    logic             reset;
    logic             req_val;
    logic             req_rdy;
    logic [2:0]       req_fn;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [TAG_W-1:0] req_tag;
    logic             kill;
    logic             resp_val;
    logic             resp_rdy;
    logic [WIDTH-1:0] resp_data;
    logic [TAG_W-1:0] resp_tag;
    logic             busy;

    riscv_core_dpath_iter_muldiv #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_val   (req_val),
        .req_rdy   (req_rdy),
        .req_fn    (req_fn),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_tag   (req_tag),
        .kill      (kill),
        .resp_val  (resp_val),
        .resp_rdy  (resp_rdy),
        .resp_data (resp_data),
        .resp_tag  (resp_tag),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [TAG_W-1:0] tag;
        int               fire_cyc;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic [2:0]       fn;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [TAG_W-1:0] tag;
        logic [WIDTH-1:0] exp;
    } vec_t;

    // Hand-computed RV32M results.
    vec_t vecs[] = '{
        '{MULH,   32'h8000_0000, 32'h8000_0000, 5'd1,  32'h4000_0000},
        '{MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE},
        '{MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFF},
        '{DIV,    32'hFFFF_FFF9, 32'd2,         5'd5,  32'hFFFF_FFFD},
        '{REM,    32'hFFFF_FFF9, 32'd2,         5'd6,  32'hFFFF_FFFF},
        '{DIVU,   32'd7,         32'd2,         5'd7,  32'd3},
        '{REMU,   32'd7,         32'd2,         5'd8,  32'd1},
        '{DIV,    32'd5,         32'd0,         5'd10, 32'hFFFF_FFFF},
        '{REM,    32'd5,         32'd0,         5'd11, 32'd5},
        '{DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000},
        '{REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0},
        '{DIVU,   32'd5,         32'd0,         5'd14, 32'hFFFF_FFFF},
        '{REM,    32'hFFFF_FFF9, 32'd0,         5'd15, 32'hFFFF_FFF9},
        '{REMU,   32'hFFFF_FFF9, 32'd0,         5'd16, 32'hFFFF_FFF9},
        '{DIV,    32'd7,         32'hFFFF_FFFE, 5'd17, 32'hFFFF_FFFD},
        '{REM,    32'd7,         32'hFFFF_FFFE, 5'd18, 32'd1},
        '{MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd19, 32'd0},
        '{MULHSU, 32'hFFFF_FFFE, 32'd2,         5'd20, 32'hFFFF_FFFF},
        '{MUL,    32'h1234_5678, 32'd0,         5'd21, 32'd0},
        '{MUL,    32'h0001_0000, 32'h0001_0001, 5'd22, 32'h0001_0000},
        '{DIVU,   32'hFFFF_FFFF, 32'd1,         5'd23, 32'hFFFF_FFFF},
        '{REMU,   32'd100,       32'd7,         5'd31, 32'd2}
    };

    // Monitor: latency on the first cycle of each response, data/tag on handshake.
    bit seen = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            seen = 1'b0;
        end else if (resp_val) begin
            if (sb.size() == 0) begin
                check("resp_unexpected", resp_val, 1'b0);
            end else begin
                if (!seen) begin
                    check("resp_latency", 64'(cyc - sb[0].fire_cyc), 64'(LAT));
                    seen = 1'b1;
                end
                if (resp_rdy) begin
                    check("resp_data", resp_data, sb[0].data);
                    check("resp_tag",  resp_tag,  sb[0].tag);
                    void'(sb.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
    task automatic issue(input logic [2:0] fn, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] tag,
                         input bit track, input logic [WIDTH-1:0] exp_data);
        exp_t e;
        int   waited = 0;
        req_fn  = fn;
        req_a   = a;
        req_b   = b;
        req_tag = tag;
        req_val = 1'b1;
        @(negedge clk);
        while (!req_rdy && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("issue_req_rdy", req_rdy, 1'b1);
        if (req_rdy && track) begin
            e.data     = exp_data;
            e.tag      = tag;
            e.fire_cyc = cyc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        req_val = 1'b0;
        // Garbage on the request bus must be ignored while not firing.
        req_fn  = 3'($urandom);
        req_a   = $urandom;
        req_b   = $urandom;
        req_tag = TAG_W'($urandom);
    endtask

    // Waits (at negedges) for resp_val with a bounded budget.
    task automatic wait_resp(input string name);
        int i = 0;
        @(negedge clk);
        while (!resp_val && i < 100) begin
            @(negedge clk);
            i++;
        end
        check(name, resp_val, 1'b1);
    endtask

    task automatic drain();
        int i = 0;
        while (sb.size() != 0 && i < 200) begin
            @(negedge clk);
            i++;
        end
        check("drain_empty", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hits;
        reset    = 1'b1;
        req_val  = 1'b0;
        req_fn   = '0;
        req_a    = '0;
        req_b    = '0;
        req_tag  = '0;
        kill     = 1'b0;
        resp_rdy = 1'b1;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_resp_val",  resp_val,  1'b0);
        check("rst_busy",      busy,      1'b0);
        check("rst_resp_data", resp_data, '0);
        check("rst_resp_tag",  resp_tag,  '0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_req_rdy", req_rdy, 1'b1);
        @(posedge clk);
        #1;

        // MUL 7 * -3 with latency and req_rdy timing around DONE.
        issue(MUL, 32'd7, 32'hFFFF_FFFD, 5'd3, 1'b1, 32'hFFFF_FFEB);
        @(negedge clk);
        check("calc_busy",    busy,    1'b1);
        check("calc_req_rdy", req_rdy, 1'b0);
        wait_resp("mul_resp_seen");
        check("done_req_rdy", req_rdy, 1'b0);
        @(negedge clk);
        check("after_done_req_rdy",  req_rdy,  1'b1);
        check("after_done_resp_val", resp_val, 1'b0);
        @(posedge clk);
        #1;

        // Directed vectors, back to back.
        foreach (vecs[i]) begin
            issue(vecs[i].fn, vecs[i].a, vecs[i].b, vecs[i].tag, 1'b1, vecs[i].exp);
        end
        drain();

        // Backpressure: result held for 10 cycles with resp_rdy low.
        resp_rdy = 1'b0;
        issue(MUL, 32'd3, 32'd5, 5'd9, 1'b1, 32'd15);
        wait_resp("bp_resp_seen");
        for (int i = 0; i < 10; i++) begin
            check("bp_resp_val",  resp_val,  1'b1);
            check("bp_resp_data", resp_data, 32'd15);
            check("bp_resp_tag",  resp_tag,  5'd9);
            check("bp_req_rdy",   req_rdy,   1'b0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        resp_rdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_release_resp_val", resp_val, 1'b0);
        check("bp_release_req_rdy",  req_rdy,  1'b1);
        @(posedge clk);
        #1;

        // Kill in CALC cycle 5: no response ever, ready again next cycle.
        issue(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd25, 1'b0, '0);
        repeat (4) @(posedge clk);
        #1;
        kill = 1'b1;
        @(negedge clk);
        check("kill_calc_busy",    busy,    1'b1);
        check("kill_calc_req_rdy", req_rdy, 1'b0);
        @(posedge clk);
        #1;
        kill = 1'b0;
        @(negedge clk);
        check("kill_next_req_rdy", req_rdy, 1'b1);
        check("kill_next_busy",    busy,    1'b0);
        hits = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (resp_val) hits++;
        end
        check("kill_no_resp", 64'(hits), 64'd0);

        // Kill in IDLE blocks acceptance.
        @(posedge clk);
        #1;
        req_fn  = DIVU;
        req_a   = 32'd9;
        req_b   = 32'd3;
        req_tag = 5'd26;
        req_val = 1'b1;
        kill    = 1'b1;
        @(negedge clk);
        check("kill_idle_req_rdy", req_rdy, 1'b0);
        @(posedge clk);
        #1;
        req_val = 1'b0;
        kill    = 1'b0;
        @(negedge clk);
        check("kill_idle_not_busy", busy, 1'b0);
        @(posedge clk);
        #1;
        issue(DIVU, 32'd100, 32'd7, 5'd27, 1'b1, 32'd14);
        drain();

        // Reset asserted mid-CALC: outputs clear at once, next op correct.
        issue(DIV, 32'd1000, 32'd3, 5'd28, 1'b0, '0);
        repeat (9) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_busy",      busy,      1'b0);
        check("midrst_resp_val",  resp_val,  1'b0);
        check("midrst_resp_data", resp_data, '0);
        check("midrst_resp_tag",  resp_tag,  '0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("midrst_req_rdy", req_rdy, 1'b1);
        @(posedge clk);
        #1;
        issue(REM, 32'hFFFF_FFF9, 32'd2, 5'd29, 1'b1, 32'hFFFF_FFFF);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
